// File: rtl/sync_tp_fifo.sv
// sync_tp_fifo: single-clock FIFO over a two-port memory with a registered read port.
// Adds pointer management, any depth >= 2, an occupancy count, almost-full and
// almost-empty thresholds, overflow/underflow pulses and an optional
// first-word-fall-through (FWFT) output stage.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   wr_en      push request
//   wr_data    push data
//   rd_en      pop request
//   rd_data    registered read data (head entry in FWFT mode)
//   rd_valid   standard: one-cycle pulse on a pop; FWFT: !empty
//   full       count == MEM_DEPTH
//   afull      count >= AFULL_TH
//   empty      standard: count == 0; FWFT: no valid output word
//   aempty     count <= AEMPTY_TH
//   count      entries held, including the FWFT output register
//   overflow   pulse: a push was dropped because the FIFO was full
//   underflow  pulse: a pop was dropped because the FIFO was empty
module sync_tp_fifo #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned MEM_DEPTH  = 12,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AFULL_TH   = 10,
    parameter int unsigned AEMPTY_TH  = 2,
    parameter int unsigned FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  afull,
    output logic                  empty,
    output logic                  aempty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

    localparam logic [CNT_WIDTH-1:0]  DEPTH_CNT  = CNT_WIDTH'(MEM_DEPTH);
    localparam logic [CNT_WIDTH-1:0]  AFULL_CNT  = CNT_WIDTH'(AFULL_TH);
    localparam logic [CNT_WIDTH-1:0]  AEMPTY_CNT = CNT_WIDTH'(AEMPTY_TH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR   = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic                  AFULL_RST  = (AFULL_TH == 0) ? 1'b1 : 1'b0;
    localparam logic                  FWFT_MODE  = (FWFT != 0) ? 1'b1 : 1'b0;

    // Storage and pointer state
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic                  out_valid;

    // Next-state values
    logic                  wr_acc;
    logic                  pop;
    logic                  mem_rd;
    logic [CNT_WIDTH-1:0]  mem_cnt;
    logic [CNT_WIDTH-1:0]  count_nxt;
    logic [ADDR_WIDTH-1:0] wptr_nxt;
    logic [ADDR_WIDTH-1:0] rptr_nxt;
    logic                  out_valid_nxt;
    logic                  rd_valid_nxt;
    logic                  empty_nxt;
    logic                  full_nxt;
    logic                  afull_nxt;
    logic                  aempty_nxt;
    logic                  overflow_nxt;
    logic                  underflow_nxt;

    // Request qualification, pointer/count update and flag look-ahead
    always_comb begin
        wr_acc        = wr_en & ~full;
        pop           = rd_en & ~empty;
        mem_cnt       = count;
        mem_rd        = pop;
        out_valid_nxt = out_valid;

        // In FWFT mode one entry may sit in rd_data rather than in memory;
        // memory is read ahead whenever the output stage is free or being drained.
        if (FWFT_MODE) begin
            pop     = rd_en & out_valid;
            mem_cnt = count - CNT_WIDTH'(out_valid);
            mem_rd  = (mem_cnt != '0) & (~out_valid | pop);
            if (mem_rd) begin
                out_valid_nxt = 1'b1;
            end else if (pop) begin
                out_valid_nxt = 1'b0;
            end
        end

        count_nxt = count + CNT_WIDTH'(wr_acc) - CNT_WIDTH'(pop);

        wptr_nxt = wptr;
        if (wr_acc) begin
            wptr_nxt = (wptr == LAST_PTR) ? '0 : wptr + ADDR_WIDTH'(1);
        end

        rptr_nxt = rptr;
        if (mem_rd) begin
            rptr_nxt = (rptr == LAST_PTR) ? '0 : rptr + ADDR_WIDTH'(1);
        end

        full_nxt   = (count_nxt == DEPTH_CNT);
        afull_nxt  = (count_nxt >= AFULL_CNT);
        aempty_nxt = (count_nxt <= AEMPTY_CNT);

        if (FWFT_MODE) begin
            empty_nxt    = ~out_valid_nxt;
            rd_valid_nxt = out_valid_nxt;
        end else begin
            empty_nxt    = (count_nxt == '0);
            rd_valid_nxt = pop;
        end

        // Dropped requests are judged against the registered flags, so a
        // simultaneous pop never rescues a push while full (and vice versa).
        overflow_nxt  = wr_en & full;
        underflow_nxt = rd_en & empty;
    end

    // Control and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            out_valid <= 1'b0;
            count     <= '0;
            rd_valid  <= 1'b0;
            full      <= 1'b0;
            afull     <= AFULL_RST;
            empty     <= 1'b1;
            aempty    <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wptr      <= wptr_nxt;
            rptr      <= rptr_nxt;
            out_valid <= out_valid_nxt;
            count     <= count_nxt;
            rd_valid  <= rd_valid_nxt;
            full      <= full_nxt;
            afull     <= afull_nxt;
            empty     <= empty_nxt;
            aempty    <= aempty_nxt;
            overflow  <= overflow_nxt;
            underflow <= underflow_nxt;
        end
    end

    // Memory write port; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wptr] <= wr_data;
        end
    end

    // Registered read port; holds between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (mem_rd) begin
            rd_data <= mem[rptr];
        end
    end

endmodule

// File: tb/tb_sync_tp_fifo.sv
// Directed bench for sync_tp_fifo: one standard-mode and one FWFT-mode instance.
module tb_sync_tp_fifo;

    localparam int unsigned DW    = 10;
    localparam int unsigned DEPTH = 12;
    localparam int unsigned AW    = 4;

    logic          clk;
    logic          rst;

    logic          s_wr_en, s_rd_en;
    logic [DW-1:0] s_wr_data, s_rd_data;
    logic          s_rd_valid, s_full, s_afull, s_empty, s_aempty, s_overflow, s_underflow;
    logic [AW:0]   s_count;

    logic          f_wr_en, f_rd_en;
    logic [DW-1:0] f_wr_data, f_rd_data;
    logic          f_rd_valid, f_full, f_afull, f_empty, f_aempty, f_overflow, f_underflow;
    logic [AW:0]   f_count;

    int n_checks;
    int n_fail;

    sync_tp_fifo #(
        .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .ADDR_WIDTH(AW),
        .AFULL_TH(10), .AEMPTY_TH(2), .FWFT(0)
    ) u_std (
        .clk(clk), .rst(rst),
        .wr_en(s_wr_en), .wr_data(s_wr_data), .rd_en(s_rd_en),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid),
        .full(s_full), .afull(s_afull), .empty(s_empty), .aempty(s_aempty),
        .count(s_count), .overflow(s_overflow), .underflow(s_underflow)
    );

    sync_tp_fifo #(
        .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .ADDR_WIDTH(AW),
        .AFULL_TH(10), .AEMPTY_TH(2), .FWFT(1)
    ) u_fwft (
        .clk(clk), .rst(rst),
        .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid),
        .full(f_full), .afull(f_afull), .empty(f_empty), .aempty(f_aempty),
        .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic std_write(input logic [DW-1:0] d);
        s_wr_en   = 1'b1;
        s_wr_data = d;
        tick();
        s_wr_en   = 1'b0;
    endtask

    logic [DW-1:0] sb[$];
    logic [DW-1:0] exp_d;
    logic [DW-1:0] wd;
    int            w, r, occ;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        s_wr_en   = 1'b0; s_rd_en = 1'b0; s_wr_data = '0;
        f_wr_en   = 1'b0; f_rd_en = 1'b0; f_wr_data = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_count",   32'(s_count),     32'd0);
        check("rst_empty",   32'(s_empty),     32'd1);
        check("rst_aempty",  32'(s_aempty),    32'd1);
        check("rst_full",    32'(s_full),      32'd0);
        check("rst_afull",   32'(s_afull),     32'd0);
        check("rst_rdvalid", 32'(s_rd_valid),  32'd0);
        check("rst_rddata",  32'(s_rd_data),   32'd0);
        check("rst_ovf",     32'(s_overflow),  32'd0);
        check("rst_udf",     32'(s_underflow), 32'd0);
        check("rst_f_empty", 32'(f_empty),     32'd1);

        // Fill to full with 0x001..0x00C
        for (int i = 1; i <= 12; i++) begin
            std_write(DW'(i));
            check("fill_count",  32'(s_count),  32'(i));
            check("fill_afull",  32'(s_afull),  32'(i >= 10));
            check("fill_aempty", 32'(s_aempty), 32'(i <= 2));
            check("fill_full",   32'(s_full),   32'(i == 12));
            check("fill_empty",  32'(s_empty),  32'd0);
        end

        // Write while full is dropped
        std_write(10'h3FF);
        check("ovf_pulse", 32'(s_overflow), 32'd1);
        check("ovf_count", 32'(s_count),    32'd12);
        tick();
        check("ovf_clear", 32'(s_overflow), 32'd0);

        // Drain with rd_en held
        s_rd_en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check("drain_data",  32'(s_rd_data),  32'(i));
            check("drain_valid", 32'(s_rd_valid), 32'd1);
            check("drain_count", 32'(s_count),    32'(12 - i));
            check("drain_empty", 32'(s_empty),    32'(i == 12));
        end
        tick();
        s_rd_en = 1'b0;
        check("udf_pulse", 32'(s_underflow), 32'd1);
        check("udf_valid", 32'(s_rd_valid),  32'd0);
        check("udf_hold",  32'(s_rd_data),   32'd12);
        tick();
        check("udf_clear", 32'(s_underflow), 32'd0);

        // Full with push and pop together: push dropped, pop taken
        for (int i = 1; i <= 12; i++) std_write(DW'(32'h100 + i));
        check("sim_full", 32'(s_full), 32'd1);
        s_wr_en = 1'b1; s_rd_en = 1'b1; s_wr_data = 10'h3FF;
        tick();
        s_wr_en = 1'b0;
        check("simf_ovf",   32'(s_overflow), 32'd1);
        check("simf_count", 32'(s_count),    32'd11);
        check("simf_data",  32'(s_rd_data),  32'h101);
        for (int i = 2; i <= 12; i++) begin
            tick();
            check("simf_drain", 32'(s_rd_data), 32'(32'h100 + i));
        end
        s_rd_en = 1'b0;
        check("simf_empty", 32'(s_empty), 32'd1);

        // Empty with push and pop together: pop dropped, push taken
        s_wr_en = 1'b1; s_rd_en = 1'b1; s_wr_data = 10'h2AB;
        tick();
        s_wr_en = 1'b0;
        check("sime_udf",   32'(s_underflow), 32'd1);
        check("sime_count", 32'(s_count),    32'd1);
        check("sime_valid", 32'(s_rd_valid), 32'd0);
        tick();
        s_rd_en = 1'b0;
        check("sime_data", 32'(s_rd_data), 32'h2AB);
        check("sime_cnt0", 32'(s_count),   32'd0);

        // Random push/pop with occupancy 1..11 against a scoreboard
        std_write(10'h200);
        sb.push_back(10'h200);
        for (int c = 0; c < 100; c++) begin
            occ = sb.size();
            w   = int'($urandom_range(0, 1));
            r   = int'($urandom_range(0, 1));
            if (occ + w - r > 11) w = 0;
            if (occ + w - r < 1)  r = 0;
            wd        = DW'($urandom_range(0, 1023));
            s_wr_en   = (w != 0);
            s_rd_en   = (r != 0);
            s_wr_data = wd;
            tick();
            if (r != 0) begin
                exp_d = sb.pop_front();
                check("rnd_data",  32'(s_rd_data),  32'(exp_d));
                check("rnd_valid", 32'(s_rd_valid), 32'd1);
            end else begin
                check("rnd_novalid", 32'(s_rd_valid), 32'd0);
            end
            if (w != 0) sb.push_back(wd);
            check("rnd_count", 32'(s_count), 32'(sb.size()));
        end
        s_wr_en = 1'b0;
        s_rd_en = 1'b0;

        // Reset mid-operation with requests pending
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) std_write(DW'(32'h050 + i));
        check("mid_count6", 32'(s_count), 32'd6);
        rst = 1'b1; s_wr_en = 1'b1; s_rd_en = 1'b1; s_wr_data = 10'h111;
        tick();
        rst = 1'b0; s_wr_en = 1'b0; s_rd_en = 1'b0;
        check("mid_count", 32'(s_count),     32'd0);
        check("mid_empty", 32'(s_empty),     32'd1);
        check("mid_valid", 32'(s_rd_valid),  32'd0);
        check("mid_udf",   32'(s_underflow), 32'd0);
        check("mid_ovf",   32'(s_overflow),  32'd0);
        std_write(10'h0AA);
        s_rd_en = 1'b1;
        tick();
        s_rd_en = 1'b0;
        check("mid_rd_data",  32'(s_rd_data),  32'h0AA);
        check("mid_rd_valid", 32'(s_rd_valid), 32'd1);

        // FWFT: first-word latency
        check("fw_rst_empty", 32'(f_empty),    32'd1);
        check("fw_rst_valid", 32'(f_rd_valid), 32'd0);
        f_wr_en = 1'b1; f_wr_data = 10'h155;
        tick();
        f_wr_en = 1'b0;
        check("fw_n_count", 32'(f_count), 32'd1);
        check("fw_n_empty", 32'(f_empty), 32'd1);
        tick();
        check("fw_n1_empty", 32'(f_empty),    32'd0);
        check("fw_n1_data",  32'(f_rd_data),  32'h155);
        check("fw_n1_valid", 32'(f_rd_valid), 32'd1);

        // FWFT: fill to full, then stream all 12 with rd_en held
        for (int i = 1; i <= 11; i++) begin
            f_wr_en = 1'b1; f_wr_data = DW'(32'h155 + i);
            tick();
        end
        f_wr_en = 1'b0;
        check("fw_full",  32'(f_full),  32'd1);
        check("fw_count", 32'(f_count), 32'd12);
        f_rd_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            check("fw_stream_data",  32'(f_rd_data), 32'(32'h155 + i));
            check("fw_stream_empty", 32'(f_empty),   32'd0);
            tick();
        end
        f_rd_en = 1'b0;
        check("fw_end_empty", 32'(f_empty),    32'd1);
        check("fw_end_valid", 32'(f_rd_valid), 32'd0);
        check("fw_end_count", 32'(f_count),    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
